// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream valid-ready bus of one pipeline stage register
//   master: producer/consumer side (drives in_*, out_ready)
//   slave : the stage itself (drives in_ready, out_*)
interface pipe_stage_reg_if #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_data;
    modport master (output in_valid, in_pc, in_data, out_ready,
                    input  in_ready, out_valid, out_pc, out_data);
    modport slave  (input  in_valid, in_pc, in_data, out_ready,
                    output in_ready, out_valid, out_pc, out_data);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: PC/payload pipeline register with 2-entry skid buffer, flush to NOP and saturating stall counter
//   clk, r (sync active-high reset), flush (sync kill of held entries)
//   bus (slave): in_valid/in_ready/in_pc/in_data upstream, out_valid/out_ready/out_pc/out_data downstream
//   full: skid entry occupied; stall_cnt: saturating count of out_valid & ~out_ready cycles
module pipe_stage_reg #(
    parameter int                PC_W    = 32,
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(32'h00000013),
    parameter int                CNT_W   = 16
) (
    input  logic             clk,
    input  logic             r,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus,
    output logic             full,
    output logic [CNT_W-1:0] stall_cnt
);
    // encoding is {main_valid, skid_valid}; 2'b01 is unreachable
    typedef enum logic [1:0] {EMPTY = 2'b00, BUSY = 2'b10, FULL = 2'b11} state_t;
    state_t            st, st_n;
    logic [PC_W-1:0]   m_pc, m_pc_n, s_pc, s_pc_n;
    logic [DATA_W-1:0] m_data, m_data_n, s_data, s_data_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              accept, pop;
    assign bus.in_ready  = ~st[0] & ~flush;
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = st[1] & bus.out_ready;
    assign bus.out_valid = st[1];
    assign bus.out_pc    = m_pc;
    assign bus.out_data  = m_data;
    assign full          = st[0];
    assign stall_cnt     = cnt;
    always_comb begin
        st_n     = st;
        m_pc_n   = m_pc;
        m_data_n = m_data;
        s_pc_n   = s_pc;
        s_data_n = s_data;
        cnt_n    = (st[1] & ~bus.out_ready & ~flush & (cnt != '1)) ? cnt + 1'b1 : cnt;
        if (flush) begin
            st_n     = EMPTY;
            m_pc_n   = '0;
            m_data_n = NOP_VAL;
            s_pc_n   = '0;
            s_data_n = NOP_VAL;
        end else if (st == EMPTY) begin
            if (accept) begin
                st_n     = BUSY;
                m_pc_n   = bus.in_pc;
                m_data_n = bus.in_data;
            end
        end else if (st == BUSY) begin
            if (accept & pop) begin
                m_pc_n   = bus.in_pc;
                m_data_n = bus.in_data;
            end else if (accept) begin
                st_n     = FULL;
                s_pc_n   = bus.in_pc;
                s_data_n = bus.in_data;
            end else if (pop) begin
                st_n     = EMPTY;
                m_pc_n   = '0;
                m_data_n = NOP_VAL;
            end
        end else if (pop) begin
            // FULL: older skid entry moves up, never overtaken by new input
            st_n     = BUSY;
            m_pc_n   = s_pc;
            m_data_n = s_data;
            s_pc_n   = '0;
            s_data_n = NOP_VAL;
        end
    end
    always_ff @(posedge clk) begin
        if (r) begin
            st     <= EMPTY;
            m_pc   <= '0;
            m_data <= NOP_VAL;
            s_pc   <= '0;
            s_data <= NOP_VAL;
            cnt    <= '0;
        end else begin
            st     <= st_n;
            m_pc   <= m_pc_n;
            m_data <= m_data_n;
            s_pc   <= s_pc_n;
            s_data <= s_data_n;
            cnt    <= cnt_n;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed plus random check of pipe_stage_reg against a queue-based FIFO model
module tb_pipe_stage_reg;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int          MAXC = 15;
    logic       clk = 0;
    logic       r, flush, full;
    logic [3:0] stall_cnt;
    int         n_cmp = 0, n_err = 0;
    logic [31:0] q_pc[$], q_data[$];
    int          cnt = 0;
    bit          live = 0;
    pipe_stage_reg_if #(.PC_W(32), .DATA_W(32)) bus ();
    pipe_stage_reg #(.PC_W(32), .DATA_W(32), .NOP_VAL(32'h00000013), .CNT_W(4)) dut (
        .clk(clk), .r(r), .flush(flush), .bus(bus), .full(full), .stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input bit rr, input bit fl, input bit iv, input logic [31:0] pc,
                       input logic [31:0] d, input bit ordy);
        bit acc, pp, stl;
        r = rr; flush = fl; bus.in_valid = iv; bus.in_pc = pc; bus.in_data = d; bus.out_ready = ordy;
        #1;
        if (live) chk("in_ready", 32'(bus.in_ready), 32'(q_pc.size() < 2 && !fl));
        @(posedge clk);
        if (rr) begin
            q_pc.delete(); q_data.delete(); cnt = 0;
        end else if (fl) begin
            q_pc.delete(); q_data.delete();
        end else begin
            acc = iv && q_pc.size() < 2;
            pp  = q_pc.size() > 0 && ordy;
            stl = q_pc.size() > 0 && !ordy;
            if (stl && cnt < MAXC) cnt++;
            if (pp) begin void'(q_pc.pop_front()); void'(q_data.pop_front()); end
            if (acc) begin q_pc.push_back(pc); q_data.push_back(d); end
        end
        live = 1;
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(q_pc.size() > 0));
        chk("out_pc", bus.out_pc, q_pc.size() > 0 ? q_pc[0] : 32'h0);
        chk("out_data", bus.out_data, q_pc.size() > 0 ? q_data[0] : NOP);
        chk("full", 32'(full), 32'(q_pc.size() == 2));
        chk("stall_cnt", 32'(stall_cnt), 32'(cnt));
    endtask
    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", bus.out_data, NOP);
        cyc(0, 0, 1, 32'h100, $urandom, 1);
        cyc(0, 0, 1, 32'h104, $urandom, 1);
        chk("stream_pc0", bus.out_pc, 32'h104);
        cyc(0, 0, 1, 32'h108, $urandom, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h200, $urandom, 1);
        cyc(0, 0, 1, 32'h204, $urandom, 0);
        chk("bp_full", 32'(full), 1);
        chk("bp_hold", bus.out_pc, 32'h200);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("bp_pop1", bus.out_pc, 32'h204);
        cyc(0, 0, 0, 0, 0, 1);
        chk("bp_stall", 32'(stall_cnt), 2);
        cyc(0, 0, 1, 32'h300, $urandom, 0);
        cyc(0, 0, 1, 32'h304, $urandom, 0);
        cyc(0, 1, 1, 32'h308, $urandom, 0);
        chk("fl_valid", 32'(bus.out_valid), 0);
        chk("fl_data", bus.out_data, NOP);
        chk("fl_full", 32'(full), 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h400, $urandom, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("drain_data", bus.out_data, NOP);
        cyc(0, 0, 1, 32'h500, $urandom, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("sat", 32'(stall_cnt), 15);
        cyc(0, 1, 0, 0, 0, 0);
        chk("sat_flush", 32'(stall_cnt), 15);
        cyc(1, 0, 0, 0, 0, 0);
        chk("sat_rst", 32'(stall_cnt), 0);
        cyc(0, 0, 1, 32'h600, $urandom, 0);
        cyc(0, 0, 1, 32'h604, $urandom, 0);
        cyc(1, 1, 1, 32'h608, $urandom, 0);
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_cnt", 32'(stall_cnt), 0);
        for (int i = 0; i < 400; i++)
            cyc($urandom % 60 == 0, $urandom % 20 == 0, $urandom % 4 != 0, $urandom, $urandom,
                $urandom % 3 != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
